// File: rtl/add4_pkg.sv
// Shared types and constants for the add4 accumulator stage.
package add4_pkg;

   typedef enum logic [0:0] {
      ST_ACCUM = 1'b0,
      ST_HOLD  = 1'b1
   } state_t;

   // Operand is {carry, sum[3:0]} from the 4-bit ripple adder.
   localparam int OPW  = 5;
   // Batch counter width; covers BATCH up to 15.
   localparam int CNTW = 4;

endpackage

// File: rtl/add4_acc_add.sv
// Combinational accumulate step: ACC_W+1-bit add of the running total and one
// adder result, producing the next total and the sticky overflow bit.
// Build option: ADD4_ACC_SATURATE_EN clamps the total to all-ones once the
// batch has overflowed; otherwise the total wraps modulo 2^ACC_W.
module add4_acc_add
   import add4_pkg::*;
#(
   parameter int ACC_W = 8
) (
   input  logic [ACC_W-1:0] acc,
   input  logic [OPW-1:0]   v,
   input  logic             ovf_in,
   output logic [ACC_W-1:0] acc_next,
   output logic             ovf_next
);

   logic [ACC_W:0] sum;

   // Zero-extended add with the carry-out kept as the overflow indicator.
   always_comb begin
      sum      = {1'b0, acc} + {{(ACC_W + 1 - OPW){1'b0}}, v};
      ovf_next = ovf_in | sum[ACC_W];
`ifdef ADD4_ACC_SATURATE_EN
      acc_next = ovf_next ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
      acc_next = sum[ACC_W-1:0];
`endif
   end

endmodule

// File: rtl/add4_accumulator.sv
// Batched summing stage behind the 4-bit ripple adder. Accepts BATCH
// {carry, sum} results, then presents the total and an overflow flag on an
// output handshake. Build option: ADD4_ACC_SATURATE_EN (see add4_acc_add).
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  ST_ACCUM  | taking results, in_ready=1, out_valid=0
//  ST_HOLD   | total presented, in_ready=0, out_valid=1 until out_ready
module add4_accumulator
   import add4_pkg::*;
#(
   parameter int BATCH = 10,
   parameter int ACC_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_sum,
   input  logic             in_carry,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_data,
   output logic             out_ovf,
   output logic [3:0]       out_count
);

   localparam logic [CNTW-1:0] LAST = CNTW'(BATCH - 1);

   state_t            state, state_d;
   logic [ACC_W-1:0]  acc, acc_d;
   logic [CNTW-1:0]   cnt, cnt_d;
   logic              ovf, ovf_d;
   logic [ACC_W-1:0]  odata, odata_d;
   logic              oovf, oovf_d;
   logic [ACC_W-1:0]  acc_nx;
   logic              ovf_nx;
   logic [OPW-1:0]    v;

   assign v = {in_carry, in_sum};

   add4_acc_add #(.ACC_W(ACC_W)) u_add (
      .acc      (acc),
      .v        (v),
      .ovf_in   (ovf),
      .acc_next (acc_nx),
      .ovf_next (ovf_nx)
   );

   // Handshake outputs decode the registered state only, so there is no
   // combinational path from out_ready to in_ready.
   assign in_ready  = (state == ST_ACCUM);
   assign out_valid = (state == ST_HOLD);
   assign out_data  = odata;
   assign out_ovf   = oovf;
   assign out_count = cnt;

   // State and datapath registers; rst takes priority over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_ACCUM;
         acc   <= '0;
         cnt   <= '0;
         ovf   <= 1'b0;
         odata <= '0;
         oovf  <= 1'b0;
      end else begin
         state <= state_d;
         acc   <= acc_d;
         cnt   <= cnt_d;
         ovf   <= ovf_d;
         odata <= odata_d;
         oovf  <= oovf_d;
      end
   end

   // Next-state and datapath update; clear wins over accept and out_ready.
   always_comb begin
      state_d = state;
      acc_d   = acc;
      cnt_d   = cnt;
      ovf_d   = ovf;
      odata_d = odata;
      oovf_d  = oovf;
      case (state)
         ST_ACCUM: begin
            if (clear) begin
               acc_d = '0;
               cnt_d = '0;
               ovf_d = 1'b0;
            end else if (in_valid) begin
               if (cnt == LAST) begin
                  odata_d = acc_nx;
                  oovf_d  = ovf_nx;
                  state_d = ST_HOLD;
               end else begin
                  acc_d = acc_nx;
                  cnt_d = cnt + CNTW'(1);
                  ovf_d = ovf_nx;
               end
            end
         end
         ST_HOLD: begin
            if (clear || out_ready) begin
               state_d = ST_ACCUM;
               acc_d   = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end
         end
         default: begin
            state_d = ST_ACCUM;
         end
      endcase
   end

endmodule

// File: tb/tb_add4_accumulator.sv
// Directed bench for add4_accumulator (BATCH=10, ACC_W=8).
module tb_add4_accumulator;

   localparam int BATCH = 10;
   localparam int ACC_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             clear;
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       in_sum;
   logic             in_carry;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_data;
   logic             out_ovf;
   logic [3:0]       out_count;

   int n_vec = 0;
   int n_err = 0;

   add4_accumulator #(.BATCH(BATCH), .ACC_W(ACC_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sum    (in_sum),
      .in_carry  (in_carry),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ovf   (out_ovf),
      .out_count (out_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] v;
      int         exp_data;
      logic       exp_ovf;
   } vec_t;

   vec_t vecs [6];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Feed n consecutive results of value v, checking the count as it climbs.
   task automatic feed(input logic [4:0] v, input int n, input bit chk_cnt);
      in_valid = 1'b1;
      {in_carry, in_sum} = v;
      for (int i = 0; i < n; i++) begin
         if (chk_cnt) check("count_climb", int'(out_count), i);
         step();
      end
      in_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_sum = '0;
      in_carry = 1'b0; out_ready = 1'b0;

      vecs[0] = '{5'd5,  50,  1'b0};
`ifdef ADD4_ACC_SATURATE_EN
      vecs[1] = '{5'd31, 255, 1'b1};
      vecs[4] = '{5'd26, 255, 1'b1};
`else
      vecs[1] = '{5'd31, 54,  1'b1};
      vecs[4] = '{5'd26, 4,   1'b1};
`endif
      vecs[2] = '{5'd0,  0,   1'b0};
      vecs[3] = '{5'd25, 250, 1'b0};
      vecs[5] = '{5'd16, 160, 1'b0};

      step(); step();
      rst = 1'b0;
      check("rst_in_ready",  int'(in_ready),  1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_data",  int'(out_data),  0);
      check("rst_out_ovf",   int'(out_ovf),   0);
      check("rst_out_count", int'(out_count), 0);

      // Table-driven batches.
      for (int k = 0; k < 6; k++) begin
         feed(vecs[k].v, BATCH, (k == 0));
         check("batch_out_valid", int'(out_valid), 1);
         check("batch_in_ready",  int'(in_ready),  0);
         check("batch_out_data",  int'(out_data),  vecs[k].exp_data);
         check("batch_out_ovf",   int'(out_ovf),   int'(vecs[k].exp_ovf));
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
         check("release_in_ready",  int'(in_ready),  1);
         check("release_out_valid", int'(out_valid), 0);
         check("release_count",     int'(out_count), 0);
      end

      // HOLD with in_valid asserted and out_ready low: nothing taken.
      feed(5'd3, BATCH, 1'b0);
      in_valid = 1'b1;
      {in_carry, in_sum} = 5'd9;
      for (int i = 0; i < 5; i++) begin
         step();
         check("hold_in_ready",  int'(in_ready),  0);
         check("hold_out_valid", int'(out_valid), 1);
         check("hold_out_data",  int'(out_data),  30);
         check("hold_count",     int'(out_count), BATCH - 1);
      end
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      out_ready = 1'b0;
      check("hold_rel_in_ready", int'(in_ready),  1);
      check("hold_rel_count",    int'(out_count), 0);
      step();
      check("hold_no_take_count", int'(out_count), 0);

      // Clear after 3 accepts, then a fresh batch.
      feed(5'd7, 3, 1'b0);
      check("pre_clear_count", int'(out_count), 3);
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("clear_count", int'(out_count), 0);
      feed(5'd1, BATCH, 1'b0);
      check("clear_batch_valid", int'(out_valid), 1);
      check("clear_batch_data",  int'(out_data),  10);
      check("clear_batch_ovf",   int'(out_ovf),   0);
      out_ready = 1'b1; step(); out_ready = 1'b0;

      // Clear coincident with the final accept drops that batch.
      feed(5'd4, BATCH - 1, 1'b0);
      in_valid = 1'b1;
      clear = 1'b1;
      step();
      in_valid = 1'b0;
      clear = 1'b0;
      check("clr_last_out_valid", int'(out_valid), 0);
      check("clr_last_count",     int'(out_count), 0);
      check("clr_last_in_ready",  int'(in_ready),  1);
      feed(5'd2, BATCH, 1'b0);
      check("after_clr_data", int'(out_data), 20);

      // Clear in HOLD discards the pending output.
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("clr_hold_out_valid", int'(out_valid), 0);
      check("clr_hold_in_ready",  int'(in_ready),  1);

      // out_ready held high with continuous input: exactly one bubble.
      out_ready = 1'b1;
      feed(5'd1, BATCH, 1'b0);
      check("bubble_in_ready", int'(in_ready), 0);
      in_valid = 1'b1;
      step();
      check("bubble_back_ready", int'(in_ready), 1);
      check("bubble_count",      int'(out_count), 0);
      step();
      in_valid = 1'b0;
      check("next_batch_count", int'(out_count), 1);
      out_ready = 1'b0;
      clear = 1'b1; step(); clear = 1'b0;

      // Reset in HOLD alongside out_ready.
      feed(5'd5, BATCH, 1'b0);
      check("pre_rst_valid", int'(out_valid), 1);
      rst = 1'b1;
      out_ready = 1'b1;
      step();
      rst = 1'b0;
      out_ready = 1'b0;
      check("rst_hold_out_valid", int'(out_valid), 0);
      check("rst_hold_out_data",  int'(out_data),  0);
      check("rst_hold_in_ready",  int'(in_ready),  1);
      check("rst_hold_out_ovf",   int'(out_ovf),   0);

      // Reset mid-batch loses the partial sum.
      feed(5'd8, 4, 1'b0);
      rst = 1'b1; step(); rst = 1'b0;
      check("rst_mid_count", int'(out_count), 0);
      feed(5'd3, BATCH, 1'b0);
      check("rst_mid_data", int'(out_data), 30);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
